// File: rtl/control_loop_sequencer_if.sv
// -----------------------------------------------------------------------------
// control_loop_sequencer_if
// Signals exchanged between the flight-control scheduler and the control loop
// sequencer.
//   master : the scheduler side. It drives the IMU strobe and health, the
//            per-stage completion levels and the error clear.
//   slave  : the sequencer. It drives the stage start strobes, loop status,
//            the sticky error report, the overrun counter and motor_enable.
// -----------------------------------------------------------------------------
interface control_loop_sequencer_if;
  logic       imu_data_valid;
  logic       imu_good;
  logic [4:0] stage_complete;
  logic       clear_err;
  logic [4:0] stage_start;
  logic       loop_busy;
  logic       loop_done;
  logic       timeout_err;
  logic [2:0] err_stage;
  logic [7:0] overrun_count;
  logic       motor_enable;

  modport master (
    output imu_data_valid, imu_good, stage_complete, clear_err,
    input  stage_start, loop_busy, loop_done, timeout_err, err_stage,
           overrun_count, motor_enable
  );

  modport slave (
    input  imu_data_valid, imu_good, stage_complete, clear_err,
    output stage_start, loop_busy, loop_done, timeout_err, err_stage,
           overrun_count, motor_enable
  );
endinterface

// File: rtl/control_loop_sequencer.sv
// -----------------------------------------------------------------------------
// control_loop_sequencer
// Runs one flight-control loop per accepted IMU sample. The five stages run in
// a fixed order: AMC, TC, YAAC, AC, BFC. Each stage receives a one-cycle start
// strobe. The sequencer then waits for a rising edge on that stage's complete
// line. If the edge does not arrive within STAGE_TIMEOUT cycles, the loop is
// abandoned. FAILSAFE_LIMIT consecutive abandoned loops latch the motors off
// until clear_err is asserted. A successful loop also releases the latch.
// Ports:
//   sys_clk : system clock. All logic runs on its rising edge.
//   resetn  : synchronous, active-low reset.
//   bus     : control_loop_sequencer_if.slave. It carries
//             imu_data_valid, imu_good, stage_complete[4:0], clear_err,
//             stage_start[4:0], loop_busy, loop_done, timeout_err,
//             err_stage[2:0], overrun_count[7:0] and motor_enable.
// Every output comes directly from a flop.
// -----------------------------------------------------------------------------
module control_loop_sequencer #(
  parameter logic [15:0] STAGE_TIMEOUT  = 16'd3800,
  parameter logic [3:0]  FAILSAFE_LIMIT = 4'd3
) (
  input  logic                    sys_clk,
  input  logic                    resetn,
  control_loop_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_FAIL  = 3'd4
  } state_t;

  localparam logic [2:0] LAST_STAGE = 3'd4;

  // Maps a stage index to its one-hot stage_start / stage_complete bit.
  function automatic logic [4:0] stage_onehot(input logic [2:0] stage);
    logic [4:0] vec;
    vec = 5'd0;
    case (stage)
      3'd0:    vec = 5'b00001;
      3'd1:    vec = 5'b00010;
      3'd2:    vec = 5'b00100;
      3'd3:    vec = 5'b01000;
      3'd4:    vec = 5'b10000;
      default: vec = 5'b00000;
    endcase
    return vec;
  endfunction

  state_t      state_r, state_s;
  logic [2:0]  idx_r, idx_s;
  logic [15:0] tmo_cnt_r, tmo_cnt_s;
  logic [16:0] tmo_inc_s;
  logic [4:0]  complete_q_r;
  logic [4:0]  complete_rise_s;
  logic        stage_hit_s;
  logic        fail_lock_s;

  logic [4:0]  stage_start_r, stage_start_s;
  logic        loop_busy_r, loop_busy_s;
  logic        loop_done_r, loop_done_s;
  logic        timeout_err_r, timeout_err_s;
  logic [2:0]  err_stage_r, err_stage_s;
  logic [7:0]  overrun_r, overrun_s;
  logic [3:0]  fail_count_r, fail_count_s;
  logic        motor_enable_r;

  // Only a rise on the active stage's line counts. A level held high counts
  // once, and completions from other stages are ignored.
  assign complete_rise_s = bus.stage_complete & ~complete_q_r;
  assign stage_hit_s     = |(complete_rise_s & stage_onehot(idx_r));
  // The counter is widened by one bit so the compare cannot wrap.
  assign tmo_inc_s       = {1'b0, tmo_cnt_r} + 17'd1;
  assign fail_lock_s     = (fail_count_r >= FAILSAFE_LIMIT);

  // Next-state logic: step through the stages. In each stage, a completion
  // edge takes priority over the stall timer.
  always_comb begin
    state_s   = state_r;
    idx_s     = idx_r;
    tmo_cnt_s = tmo_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.imu_data_valid && bus.imu_good) begin
          state_s = ST_START;
          idx_s   = 3'd0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_START: begin
        state_s   = ST_WAIT;
        tmo_cnt_s = 16'd0;
      end
      ST_WAIT: begin
        if (stage_hit_s) begin
          if (idx_r == LAST_STAGE) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_START;
            idx_s   = idx_r + 3'd1;
          end
        end else if (tmo_inc_s >= {1'b0, STAGE_TIMEOUT}) begin
          state_s = ST_FAIL;
        end else begin
          tmo_cnt_s = tmo_inc_s[15:0];
        end
      end
      ST_DONE: state_s = ST_IDLE;
      ST_FAIL: state_s = ST_IDLE;
      default: begin
        state_s   = ST_IDLE;
        idx_s     = 3'd0;
        tmo_cnt_s = 16'd0;
      end
    endcase
  end

  // Output next-values are decoded from the next state, so that the registered
  // ports line up with the state they describe.
  always_comb begin
    stage_start_s = 5'd0;
    loop_busy_s   = 1'b0;
    loop_done_s   = 1'b0;
    timeout_err_s = timeout_err_r;
    err_stage_s   = err_stage_r;
    fail_count_s  = fail_count_r;
    overrun_s     = overrun_r;

    if (state_s == ST_START) begin
      stage_start_s = stage_onehot(idx_s);
    end else begin
      stage_start_s = 5'd0;
    end
    loop_busy_s = (state_s != ST_IDLE);
    loop_done_s = (state_s == ST_DONE);

    // A failing loop outranks a simultaneous clear_err, so the report is never lost.
    if (state_s == ST_FAIL) begin
      timeout_err_s = 1'b1;
      err_stage_s   = idx_r;
      if (fail_count_r != 4'hF) begin
        fail_count_s = fail_count_r + 4'd1;
      end else begin
        fail_count_s = 4'hF;
      end
    end else if (bus.clear_err) begin
      timeout_err_s = 1'b0;
      err_stage_s   = 3'd0;
      fail_count_s  = 4'd0;
    end else if (state_s == ST_DONE) begin
      timeout_err_s = timeout_err_r;
      err_stage_s   = err_stage_r;
      fail_count_s  = 4'd0;
    end else begin
      timeout_err_s = timeout_err_r;
      err_stage_s   = err_stage_r;
      fail_count_s  = fail_count_r;
    end

    // Strobes that arrive while a loop is running are dropped and counted.
    if (bus.clear_err) begin
      overrun_s = 8'd0;
    end else if (loop_busy_r && bus.imu_data_valid && (overrun_r != 8'hFF)) begin
      overrun_s = overrun_r + 8'd1;
    end else begin
      overrun_s = overrun_r;
    end
  end

  // Sequencer state register: state, stage index and stall timer.
  always_ff @(posedge sys_clk) begin
    if (!resetn) begin
      state_r   <= ST_IDLE;
      idx_r     <= 3'd0;
      tmo_cnt_r <= 16'd0;
    end else begin
      state_r   <= state_s;
      idx_r     <= idx_s;
      tmo_cnt_r <= tmo_cnt_s;
    end
  end

  // Registered outputs, sticky status and the edge-detect copy of stage_complete.
  always_ff @(posedge sys_clk) begin
    if (!resetn) begin
      complete_q_r   <= 5'd0;
      stage_start_r  <= 5'd0;
      loop_busy_r    <= 1'b0;
      loop_done_r    <= 1'b0;
      timeout_err_r  <= 1'b0;
      err_stage_r    <= 3'd0;
      overrun_r      <= 8'd0;
      fail_count_r   <= 4'd0;
      motor_enable_r <= 1'b0;
    end else begin
      complete_q_r   <= bus.stage_complete;
      stage_start_r  <= stage_start_s;
      loop_busy_r    <= loop_busy_s;
      loop_done_r    <= loop_done_s;
      timeout_err_r  <= timeout_err_s;
      err_stage_r    <= err_stage_s;
      overrun_r      <= overrun_s;
      fail_count_r   <= fail_count_s;
      motor_enable_r <= bus.imu_good & ~fail_lock_s;
    end
  end

  assign bus.stage_start   = stage_start_r;
  assign bus.loop_busy     = loop_busy_r;
  assign bus.loop_done     = loop_done_r;
  assign bus.timeout_err   = timeout_err_r;
  assign bus.err_stage     = err_stage_r;
  assign bus.overrun_count = overrun_r;
  assign bus.motor_enable  = motor_enable_r;

endmodule

// File: tb/tb_control_loop_sequencer.sv
// -----------------------------------------------------------------------------
// tb_control_loop_sequencer
// Self-checking bench for control_loop_sequencer, built with STAGE_TIMEOUT=20
// and FAILSAFE_LIMIT=3.
// Before each loop, the bench plans the expected timeline from the stage
// delays: the cycle of every stage start, the completion pulses, and the
// DONE/FAIL cycle. It then drives the loop and compares the outputs on every
// cycle. Sticky status, the overrun count and motor_enable are tracked by a
// small event model.
// -----------------------------------------------------------------------------
module tb_control_loop_sequencer;
  localparam int TO = 20;
  localparam int FL = 3;

  logic sys_clk = 1'b0;
  logic resetn;
  control_loop_sequencer_if bus();

  control_loop_sequencer #(.STAGE_TIMEOUT(16'd20), .FAILSAFE_LIMIT(4'd3)) dut (
    .sys_clk (sys_clk),
    .resetn  (resetn),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks   = 0;
  int n_fail     = 0;
  int cyc        = 0;
  int first_done = -1;

  // Model of the externally visible status.
  int m_fail;
  int m_ovr;
  int m_estage;
  bit m_terr;
  bit m_me;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, got, exp);
    end
  endtask

  // Applies the status rules for the inputs of the current cycle, then
  // advances one clock. fail_next and done_next say whether the following
  // cycle is the loop's FAIL or DONE cycle.
  task automatic tick(input bit busy_now, input bit fail_next, input bit done_next, input int stg);
    int nfail;
    m_me  = bus.imu_good && (m_fail < FL);
    nfail = m_fail;
    if (bus.clear_err) begin
      m_terr   = 1'b0;
      m_estage = 0;
      nfail    = 0;
      m_ovr    = 0;
    end else if (bus.imu_data_valid && busy_now && m_ovr < 255) begin
      m_ovr++;
    end
    if (fail_next) begin
      m_terr   = 1'b1;
      m_estage = stg;
      nfail    = (m_fail < 15) ? m_fail + 1 : 15;
    end
    if (done_next) nfail = 0;
    m_fail = nfail;
    @(posedge sys_clk);
    @(negedge sys_clk);
    cyc++;
    check_val("timeout_err", int'(bus.timeout_err), int'(m_terr));
    check_val("err_stage", int'(bus.err_stage), m_estage);
    check_val("overrun_count", int'(bus.overrun_count), m_ovr);
    check_val("motor_enable", int'(bus.motor_enable), int'(m_me));
  endtask

  task automatic do_reset(input int n);
    resetn             = 1'b0;
    bus.imu_data_valid = 1'b0;
    bus.stage_complete = 5'd0;
    bus.clear_err      = 1'b0;
    bus.imu_good       = 1'b1;
    repeat (n) begin
      @(posedge sys_clk);
      @(negedge sys_clk);
    end
    check_val("rst_stage_start", int'(bus.stage_start), 0);
    check_val("rst_loop_busy", int'(bus.loop_busy), 0);
    check_val("rst_loop_done", int'(bus.loop_done), 0);
    check_val("rst_timeout_err", int'(bus.timeout_err), 0);
    check_val("rst_err_stage", int'(bus.err_stage), 0);
    check_val("rst_overrun", int'(bus.overrun_count), 0);
    check_val("rst_motor_enable", int'(bus.motor_enable), 0);
    m_fail = 0; m_ovr = 0; m_estage = 0; m_terr = 1'b0; m_me = 1'b0;
    resetn = 1'b1;
    cyc    = 0;
  endtask

  task automatic idle(input int n, input int clear_at);
    for (int t = 0; t < n; t++) begin
      bus.imu_data_valid = 1'b0;
      bus.stage_complete = 5'd0;
      bus.imu_good       = 1'b1;
      bus.clear_err      = (t == clear_at);
      check_val("idle_busy", int'(bus.loop_busy), 0);
      check_val("idle_start", int'(bus.stage_start), 0);
      tick(1'b0, 1'b0, 1'b0, 0);
    end
    bus.clear_err = 1'b0;
  endtask

  // One loop request. A delay greater than TO means the stage never completes.
  task automatic run_loop(input bit good, input int d0, input int d1, input int d2,
                          input int d3, input int d4, input int clear_at,
                          input int ovr_pct, input bit noise);
    int d[5];
    logic [4:0] est[256];
    logic [4:0] pulse[256];
    int stg[256];
    bit in_wait[256];
    int s, endt, fstg, j;
    bit ok_end, exp_busy;
    logic [4:0] cmp;
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3; d[4] = d4;
    for (int k = 0; k < 256; k++) begin
      est[k] = 5'd0; pulse[k] = 5'd0; stg[k] = 0; in_wait[k] = 1'b0;
    end
    endt = 0; fstg = 0; ok_end = 1'b0;
    if (good) begin
      s    = 1;
      endt = -1;
      for (int i = 0; i < 5; i++) begin
        if (endt < 0) begin
          est[s] = 5'b00001 << i;
          if (d[i] <= TO) begin
            for (int k = s + 1; k <= s + d[i]; k++) begin in_wait[k] = 1'b1; stg[k] = i; end
            pulse[s + d[i]] = 5'b00001 << i;
            s = s + d[i] + 1;
            if (i == 4) begin endt = s; ok_end = 1'b1; end
          end else begin
            for (int k = s + 1; k <= s + TO; k++) begin in_wait[k] = 1'b1; stg[k] = i; end
            endt = s + TO + 1;
            fstg = i;
          end
        end
      end
    end
    for (int t = 0; t <= endt + 2; t++) begin
      exp_busy           = good && (t >= 1) && (t <= endt);
      bus.imu_data_valid = (t == 0) || (exp_busy && ($urandom_range(0, 99) < ovr_pct));
      bus.imu_good       = (noise && exp_busy) ? ($urandom_range(0, 99) < 85) : good;
      cmp = pulse[t];
      if (noise && in_wait[t] && $urandom_range(0, 3) == 0) begin
        j = $urandom_range(0, 4);
        if (j != stg[t]) cmp = cmp | (5'b00001 << j);
      end
      bus.stage_complete = cmp;
      bus.clear_err      = (t == clear_at);
      check_val("stage_start", int'(bus.stage_start), int'(est[t]));
      check_val("loop_busy", int'(bus.loop_busy), int'(exp_busy));
      check_val("loop_done", int'(bus.loop_done), int'(ok_end && (t == endt)));
      if (bus.loop_done && first_done < 0) first_done = cyc;
      tick(exp_busy, good && !ok_end && (t + 1 == endt), ok_end && (t + 1 == endt), fstg);
    end
    bus.imu_data_valid = 1'b0;
    bus.stage_complete = 5'd0;
    bus.clear_err      = 1'b0;
  endtask

  function automatic int rand_dly();
    int r;
    r = $urandom_range(0, 19);
    if (r < 14)      return $urandom_range(1, 6);
    else if (r < 16) return TO;
    else if (r < 18) return TO + 1;
    else             return 99;
  endfunction

  initial begin
    resetn = 1'b0;
    do_reset(3);

    // Nominal loop: strobe at cycle 10, every stage completes 5 cycles after its start.
    idle(10, -1);
    run_loop(1'b1, 5, 5, 5, 5, 5, -1, 0, 1'b0);
    check_val("nominal_done_cycle", first_done, 41);

    // YAAC stalls.
    run_loop(1'b1, 3, 3, 99, 3, 3, -1, 0, 1'b0);
    check_val("tmo_err_stage", int'(bus.err_stage), 2);
    check_val("tmo_flag", int'(bus.timeout_err), 1);
    idle(3, 0);

    // Three consecutive TC timeouts latch the motors off; clear_err releases them.
    repeat (3) run_loop(1'b1, 2, 99, 2, 2, 2, -1, 0, 1'b0);
    check_val("failsafe_motor_off", int'(bus.motor_enable), 0);
    idle(4, 0);
    check_val("failsafe_motor_back", int'(bus.motor_enable), 1);

    // A clear_err in the cycle before FAIL loses to the FAIL update.
    run_loop(1'b1, 99, 1, 1, 1, 1, 21, 0, 1'b0);
    check_val("clear_vs_fail", int'(bus.timeout_err), 1);

    // A completion in the last allowed cycle wins; one cycle later is a timeout.
    run_loop(1'b1, TO, TO, TO, TO, TO, -1, 0, 1'b0);
    run_loop(1'b1, 1, 1, 1, TO + 1, 1, -1, 0, 1'b0);
    idle(2, 0);

    // Overrun saturation.
    repeat (3) run_loop(1'b1, TO, TO, TO, TO, 99, -1, 100, 1'b0);
    check_val("overrun_sat", int'(bus.overrun_count), 255);
    idle(3, 0);
    check_val("overrun_cleared", int'(bus.overrun_count), 0);

    // Gating: a strobe with imu_good low is ignored.
    run_loop(1'b0, 1, 1, 1, 1, 1, -1, 0, 1'b0);
    check_val("gate_overrun", int'(bus.overrun_count), 0);
    check_val("gate_motor", int'(bus.motor_enable), 0);
    idle(2, -1);

    // Reset during the stage 3 wait aborts the loop.
    bus.imu_data_valid = 1'b1;
    check_val("abort_pre_busy", int'(bus.loop_busy), 0);
    tick(1'b0, 1'b0, 1'b0, 0);
    bus.imu_data_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_val("abort_seq_start", int'(bus.stage_start), 1 << i);
      tick(1'b1, 1'b0, 1'b0, 0);
      bus.stage_complete = 5'b00001 << i;
      tick(1'b1, 1'b0, 1'b0, 0);
      bus.stage_complete = 5'd0;
    end
    check_val("abort_seq_start3", int'(bus.stage_start), 8);
    tick(1'b1, 1'b0, 1'b0, 0);
    tick(1'b1, 1'b0, 1'b0, 0);
    check_val("abort_wait_busy", int'(bus.loop_busy), 1);
    do_reset(1);
    run_loop(1'b1, 2, 2, 2, 2, 2, -1, 0, 1'b0);

    // Randomised loops with noise on other stages, imu_good jitter,
    // overrun strobes and stray clears.
    for (int n = 0; n < 40; n++) begin
      run_loop($urandom_range(0, 9) != 0, rand_dly(), rand_dly(), rand_dly(), rand_dly(),
               rand_dly(), ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 40)) : -1,
               20, 1'b1);
      idle($urandom_range(0, 3), ($urandom_range(0, 4) == 0) ? 0 : -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/control_loop_sequencer.md
CONTROL_LOOP_SEQUENCER -- requirements
Module: control_loop_sequencer

Interface
REQ-001 Parameter STAGE_TIMEOUT, default 16'd3800, max sys_clk cycles allowed per stage (100 us at 38 MHz).
REQ-002 Parameter FAILSAFE_LIMIT, default 4'd3, consecutive failed loops before motors are disabled.
REQ-003 sys_clk  input  1  system clock (38 MHz); all logic on its rising edge.
REQ-004 resetn  input  1  reset; synchronous, active-low; clock sys_clk.
REQ-005 imu_data_valid  input  1  one-cycle strobe; new IMU sample available, requests one loop.
REQ-006 imu_good  input  1  level; IMU healthy.
REQ-007 stage_complete  input  5  per-stage done, bit0=AMC, 1=TC, 2=YAAC, 3=AC, 4=BFC; synchronous to sys_clk; rising edge counts.
REQ-008 clear_err  input  1  one-cycle strobe; clears sticky errors and failsafe latch.
REQ-009 stage_start  output  5  one-hot, one-cycle start strobe per stage.
REQ-010 loop_busy  output  1  high while a loop is in progress.
REQ-011 loop_done  output  1  one-cycle strobe; loop finished without error.
REQ-012 timeout_err  output  1  sticky; a stage timed out.
REQ-013 err_stage  output  3  index (0-4) of the most recent timed-out stage.
REQ-014 overrun_count  output  8  saturating count of dropped imu_data_valid strobes.
REQ-015 motor_enable  output  1  high when motors may be driven from mixer rates.

Function
REQ-016 States SHALL be IDLE, START, WAIT, DONE, FAIL; a 3-bit stage index idx (0-4) SHALL be held alongside them.
REQ-017 Stage-complete edges SHALL be detected against a registered copy of stage_complete; a held-high level SHALL count once.
REQ-018 IDLE: when imu_data_valid=1 and imu_good=1, go to START with idx=0; imu_data_valid with imu_good=0 SHALL be ignored and not counted.
REQ-019 START: stage_start[idx]=1 for exactly one cycle, clear the timeout counter, go to WAIT.
REQ-020 WAIT: a rising edge on stage_complete[idx] with idx<4 SHALL set idx+1 and go to START; with idx=4 it SHALL go to DONE.
REQ-021 Edges on stage_complete bits other than idx SHALL be ignored.
REQ-022 Latency: imu_data_valid in cycle N gives stage_start[0] in N+1.
REQ-023 Latency: a complete edge sampled in cycle M gives the next stage_start, or loop_done, in M+1.
REQ-024 WAIT timeout: the counter increments each cycle; when it reaches STAGE_TIMEOUT with no edge, go to FAIL.
REQ-025 If an edge and the timeout coincide in the same cycle, the edge SHALL win.
REQ-026 DONE: loop_done=1 for one cycle, fail_count cleared to 0, return to IDLE.
REQ-027 FAIL (one cycle): timeout_err=1, err_stage=idx, fail_count increments saturating at 15, return to IDLE; no further stage_start for that loop.
REQ-028 loop_busy SHALL be 1 in START, WAIT, DONE and FAIL, and 0 in IDLE.
REQ-029 imu_data_valid while loop_busy=1 SHALL be dropped; overrun_count increments and holds at 255.
REQ-030 fail_lock SHALL set when fail_count >= FAILSAFE_LIMIT.
REQ-031 motor_enable SHALL equal (imu_good & ~fail_lock), registered, so it updates one cycle after its inputs.
REQ-032 clear_err SHALL clear timeout_err, err_stage, fail_count, fail_lock and overrun_count next cycle without disturbing an in-progress loop.
REQ-033 If clear_err and a FAIL update coincide, the FAIL update SHALL win.
REQ-034 If imu_good falls mid-loop, the loop SHALL continue; motor_enable SHALL drop next cycle.

Reset
REQ-035 resetn=0 at a clock edge SHALL force IDLE with idx=0 and zero the timeout counter and fail_count.
REQ-036 During reset, all outputs SHALL be 0: stage_start, loop_busy, loop_done, timeout_err, err_stage, overrun_count, motor_enable.
REQ-037 Reset asserted mid-loop SHALL abort the loop with no further stage_start.
REQ-038 The edge-detect register SHALL reset to 0, so a complete input held high at reset release counts as an edge.

Verification
REQ-039 Nominal: imu_good=1, strobe at cycle 10, each stage completes 5 cycles after its start -> stage_start[0..4] at cycles 11, 17, 23, 29, 35; loop_done at 41; timeout_err=0.
REQ-040 Timeout: with STAGE_TIMEOUT=16'd20, YAAC never completes -> FAIL after 20 WAIT cycles, err_stage=2, timeout_err=1, stage_start[3] never asserted.
REQ-041 Failsafe: 3 consecutive TC timeouts -> motor_enable drops 1 cycle after the third FAIL; clear_err -> motor_enable returns to 1 two cycles later.
REQ-042 Overrun: 300 imu_data_valid strobes while a stage is stalled -> overrun_count=255 and stays there; clear_err -> 0.
REQ-043 Gating: imu_good=0 with strobe -> no stage_start, overrun_count unchanged, motor_enable=0.
REQ-044 Reset mid-loop: resetn=0 during WAIT idx=3 -> all outputs 0 next cycle; after release, a new strobe restarts at stage_start[0].
